// File: rtl/window_address_sequencer_pkg.sv
// rtl/window_address_sequencer_pkg.sv - shared state encoding and border mode constants
package window_address_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SHIFT,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam logic BORDER_ZERO = 1'b0;
    localparam logic BORDER_REPL = 1'b1;

endpackage

// File: rtl/window_address_sequencer_border_resolve.sv
// rtl/window_address_sequencer_border_resolve.sv - clamp a signed window coordinate to 0..limit-1
module window_address_sequencer_border_resolve
    import window_address_sequencer_pkg::*;
#(
    parameter int WORD = 8
) (
    input  logic signed [WORD+1:0] coord_i,
    input  logic [WORD-1:0]        limit_i,
    input  logic                   border_i,
    output logic [WORD-1:0]        coord_o,
    output logic                   in_range_o
);

    logic signed [WORD+1:0] limit_s;
    assign limit_s = signed'({2'b00, limit_i});

    always_comb begin
        coord_o    = '0;
        in_range_o = 1'b0;
        if (coord_i[WORD+1]) begin
            coord_o = '0;
        end else if (coord_i >= limit_s) begin
            coord_o = limit_i - WORD'(1);
        end else begin
            coord_o    = coord_i[WORD-1:0];
            in_range_o = 1'b1;
        end
        // Zero mode never addresses memory outside the image, so drop the clamp.
        if (!in_range_o && border_i != BORDER_REPL) begin
            coord_o = '0;
        end
    end

endmodule

// File: rtl/window_address_sequencer.sv
// rtl/window_address_sequencer.sv - n x n window read/write address sequencer with border modes
module window_address_sequencer
    import window_address_sequencer_pkg::*;
#(
    parameter int                WORD     = 8,
    parameter int                ADDR_W   = 16,
    parameter int                MAX_N    = 7,
    parameter int                CH       = 4,
    parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000,
    localparam int               CW       = $clog2(CH + 1),
    localparam int               SW       = WORD + 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [WORD-1:0]   h_i,
    input  logic [WORD-1:0]   w_i,
    input  logic [WORD-1:0]   n_i,
    input  logic              border_i,
    input  logic [CW-1:0]     chans_i,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] address_o,
    output logic              r_en_o,
    output logic              w_en_o,
    output logic              pad_o,
    output logic              kernel_newline_o,
    output logic              kernel_clk_o,
    output logic              kernel_running_o,
    output logic              done_o
);

    state_e state_q, state_d;
    logic [WORD-1:0] h_q, h_d, w_q, w_d, n_q, n_d, r_q, r_d;
    logic            border_q, border_d;
    logic [CW-1:0]   chans_q, chans_d, c_q, c_d;
    logic [WORD-1:0] y_q, y_d, k_q, k_d;
    logic signed [SW-1:0] xs_q, xs_d, yy_q, yy_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, start_ptr_q, start_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

    logic [WORD-1:0]   r_in, x_cl, y_cl;
    logic              x_in, y_in, cfg_ok, wr_col;
    logic signed [SW-1:0] r_s, r_in_s, last_xs;
    logic [ADDR_W-1:0] wz;

    assign r_in    = {1'b0, n_i[WORD-1:1]};
    assign r_in_s  = signed'({2'b00, r_in});
    assign r_s     = signed'({2'b00, r_q});
    assign last_xs = signed'({2'b00, w_q}) - SW'(1) + r_s;
    assign wz      = {{(ADDR_W-WORD){1'b0}}, w_q};
    assign wr_col  = (xs_q >= r_s);
    assign cfg_ok  = n_i[0] && (n_i <= WORD'(MAX_N)) && (h_i != '0) && (w_i != '0)
                     && (chans_i != '0) && (chans_i <= CW'(CH));

    window_address_sequencer_border_resolve #(.WORD(WORD)) u_res_y (
        .coord_i   (yy_q),
        .limit_i   (h_q),
        .border_i  (border_q),
        .coord_o   (y_cl),
        .in_range_o(y_in)
    );

    window_address_sequencer_border_resolve #(.WORD(WORD)) u_res_x (
        .coord_i   (xs_q),
        .limit_i   (w_q),
        .border_i  (border_q),
        .coord_o   (x_cl),
        .in_range_o(x_in)
    );

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        w_d         = w_q;
        n_d         = n_q;
        r_d         = r_q;
        border_d    = border_q;
        chans_d     = chans_q;
        c_d         = c_q;
        y_d         = y_q;
        k_d         = k_q;
        xs_d        = xs_q;
        yy_d        = yy_q;
        row_base_d  = row_base_q;
        start_ptr_d = start_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        address_o        = '0;
        r_en_o           = 1'b0;
        w_en_o           = 1'b0;
        pad_o            = 1'b0;
        kernel_newline_o = 1'b0;
        kernel_clk_o     = 1'b0;
        kernel_running_o = 1'b0;
        done_o           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    h_d         = h_i;
                    w_d         = w_i;
                    n_d         = n_i;
                    r_d         = r_in;
                    border_d    = border_i;
                    chans_d     = chans_i;
                    c_d         = '0;
                    y_d         = '0;
                    k_d         = '0;
                    xs_d        = -r_in_s;
                    yy_d        = -r_in_s;
                    row_base_d  = '0;
                    start_ptr_d = '0;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = OUT_BASE;
                    state_d     = cfg_ok ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                kernel_running_o = 1'b1;
                kernel_newline_o = (k_q == '0) && (xs_q == -r_s);
                r_en_o           = (border_q == BORDER_REPL) || (x_in && y_in);
                pad_o            = !r_en_o;
                address_o        = r_en_o ? rd_ptr_q + ADDR_W'(x_cl) : '0;
                if (ready_i) begin
                    if (k_q == n_q - WORD'(1)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        k_d  = k_q + WORD'(1);
                        yy_d = yy_q + SW'(1);
                        // rd_ptr tracks the clamped row, so it only moves while inside the image
                        if (y_in && y_cl != h_q - WORD'(1)) begin
                            rd_ptr_d = rd_ptr_q + wz;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                kernel_running_o = 1'b1;
                kernel_clk_o     = ready_i;
                if (ready_i) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                kernel_running_o = 1'b1;
                w_en_o           = wr_col;
                address_o        = wr_col ? wr_ptr_q : '0;
                if (ready_i) begin
                    state_d = ST_READ;
                    k_d     = '0;
                    if (wr_col) begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                    if (xs_q == last_xs) begin
                        xs_d = -r_s;
                        if (y_q == h_q - WORD'(1)) begin
                            if (c_q == chans_q - CW'(1)) begin
                                state_d = ST_DONE;
                            end else begin
                                c_d         = c_q + CW'(1);
                                y_d         = '0;
                                row_base_d  = row_base_q + wz;
                                start_ptr_d = row_base_q + wz;
                            end
                        end else begin
                            y_d        = y_q + WORD'(1);
                            row_base_d = row_base_q + wz;
                            // Top window row stays clamped at 0 until y reaches r.
                            if (y_q >= r_q) begin
                                start_ptr_d = start_ptr_q + wz;
                            end
                        end
                    end else begin
                        xs_d = xs_q + SW'(1);
                    end
                    yy_d     = signed'({2'b00, y_d}) - r_s;
                    rd_ptr_d = start_ptr_d;
                end
            end
            ST_DONE: begin
                done_o = ready_i;
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            w_q         <= '0;
            n_q         <= '0;
            r_q         <= '0;
            border_q    <= BORDER_ZERO;
            chans_q     <= '0;
            c_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            xs_q        <= '0;
            yy_q        <= '0;
            row_base_q  <= '0;
            start_ptr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            w_q         <= w_d;
            n_q         <= n_d;
            r_q         <= r_d;
            border_q    <= border_d;
            chans_q     <= chans_d;
            c_q         <= c_d;
            y_q         <= y_d;
            k_q         <= k_d;
            xs_q        <= xs_d;
            yy_q        <= yy_d;
            row_base_q  <= row_base_d;
            start_ptr_q <= start_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

endmodule

// File: tb/tb_window_address_sequencer.sv
// tb/tb_window_address_sequencer.sv - self-checking bench with a scan-order reference model
module tb_window_address_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        run_i = 1'b0;
    logic [7:0]  h_i = '0, w_i = '0, n_i = '0;
    logic        border_i = 1'b0;
    logic [2:0]  chans_i = '0;
    logic        ready_i = 1'b1;
    logic [15:0] address_o;
    logic        r_en_o, w_en_o, pad_o, kernel_newline_o, kernel_clk_o, kernel_running_o, done_o;

    always #5 clk_i = ~clk_i;

    window_address_sequencer dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .run_i           (run_i),
        .h_i             (h_i),
        .w_i             (w_i),
        .n_i             (n_i),
        .border_i        (border_i),
        .chans_i         (chans_i),
        .ready_i         (ready_i),
        .address_o       (address_o),
        .r_en_o          (r_en_o),
        .w_en_o          (w_en_o),
        .pad_o           (pad_o),
        .kernel_newline_o(kernel_newline_o),
        .kernel_clk_o    (kernel_clk_o),
        .kernel_running_o(kernel_running_o),
        .done_o          (done_o)
    );

    typedef struct packed {
        logic [15:0] a;
        logic re, we, pd, nl, kc, kr, dn;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   checking = 0;
    int   ccyc, done_cyc, kclk_n, nl_n, pad_n, wen_n, ren_n;
    exp_t first_v[3];

    function automatic exp_t cur_out();
        cur_out = {address_o, r_en_o, w_en_o, pad_o, kernel_newline_o,
                   kernel_clk_o, kernel_running_o, done_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected output per accepted cycle, straight from the scan order.
    task automatic build(input int h, input int w, input int n, input int bm, input int ch);
        int   r, yy, cy, cx;
        bit   ok;
        exp_t e;
        ok = (n % 2 == 1) && n <= 7 && h > 0 && w > 0 && ch > 0 && ch <= 4;
        if (!ok) begin
            e = '0; e.dn = 1'b1; exp_q.push_back(e);
        end else begin
            r = (n - 1) / 2;
            for (int c = 0; c < ch; c++)
                for (int y = 0; y < h; y++)
                    for (int xs = -r; xs <= w - 1 + r; xs++) begin
                        for (int dy = -r; dy <= r; dy++) begin
                            e = '0; e.kr = 1'b1; yy = y + dy;
                            e.nl = (dy == -r && xs == -r);
                            if (yy >= 0 && yy < h && xs >= 0 && xs < w) begin
                                e.re = 1'b1; e.a = 16'(c*h*w + yy*w + xs);
                            end else if (bm != 0) begin
                                cy = (yy < 0) ? 0 : ((yy >= h) ? h - 1 : yy);
                                cx = (xs < 0) ? 0 : ((xs >= w) ? w - 1 : xs);
                                e.re = 1'b1; e.a = 16'(c*h*w + cy*w + cx);
                            end else begin
                                e.pd = 1'b1;
                            end
                            exp_q.push_back(e);
                        end
                        e = '0; e.kr = 1'b1; e.kc = 1'b1; exp_q.push_back(e);
                        e = '0; e.kr = 1'b1;
                        if (xs >= r) begin
                            e.we = 1'b1; e.a = 16'(32768 + c*h*w + y*w + xs - r);
                        end
                        exp_q.push_back(e);
                    end
            e = '0; e.dn = 1'b1; exp_q.push_back(e);
        end
        e = '0; exp_q.push_back(e);
    endtask

    always @(negedge clk_i) begin
        exp_t e, act;
        if (checking && exp_q.size() > 0) begin
            e   = exp_q[0];
            act = cur_out();
            if (!ready_i) begin
                e.kc = 1'b0; e.dn = 1'b0;
            end
            chk($sformatf("cycle%0d", ccyc), 32'(act), 32'(e));
            if (ready_i) begin
                if (act.dn) done_cyc = ccyc;
                if (act.kc) kclk_n++;
                if (act.nl) nl_n++;
                if (act.pd) pad_n++;
                if (act.we) wen_n++;
                if (act.re) ren_n++;
                if (ccyc <= 3) first_v[ccyc-1] = act;
                void'(exp_q.pop_front());
            end
            ccyc++;
        end
    end

    task automatic do_run(input int h, input int w, input int n, input int bm, input int ch,
                          input int s0, input int slen, input int abort);
        int cyc;
        bit ab;
        done_cyc = -1; kclk_n = 0; nl_n = 0; pad_n = 0; wen_n = 0; ren_n = 0;
        ccyc = 1; ab = 0;
        build(h, w, n, bm, ch);
        @(posedge clk_i); #1;
        h_i = 8'(h); w_i = 8'(w); n_i = 8'(n); border_i = bm[0]; chans_i = 3'(ch);
        run_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        run_i = 1'b0; h_i = 8'd2; w_i = 8'd9; n_i = 8'd4; border_i = ~bm[0]; chans_i = 3'd3;
        checking = 1; cyc = 1;
        while (exp_q.size() > 0 && cyc < 3000 && !ab) begin
            if (abort > 0 && cyc == abort) begin
                checking = 0;
                #1 rst_ni = 1'b0;
                #1 chk("async_reset_outputs", 32'(cur_out()), 32'd0);
                ab = 1;
                @(posedge clk_i); #1 rst_ni = 1'b1;
                exp_q.delete();
            end else begin
                ready_i = (cyc >= s0 && cyc < s0 + slen) ? 1'b0 : 1'b1;
                run_i   = (cyc == 10);
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        checking = 0; run_i = 1'b0; ready_i = 1'b1;
        if (!ab) chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 chk("reset_state", 32'(cur_out()), 32'd0);
        rst_ni = 1'b1;

        do_run(4, 4, 3, 0, 1, 0, 0, 0);
        chk("t1_done_cycle", done_cyc, 121);
        chk("t1_writes", wen_n, 16);
        chk("t1_pads", pad_n, 32);
        chk("t1_newlines", nl_n, 4);
        chk("t1_kernel_clks", kclk_n, 24);

        do_run(4, 4, 3, 1, 1, 0, 0, 0);
        chk("t2_done_cycle", done_cyc, 121);
        chk("t2_rd0", 32'({first_v[0].a, first_v[0].re, first_v[0].pd}), 32'({16'd0, 1'b1, 1'b0}));
        chk("t2_rd1", 32'({first_v[1].a, first_v[1].re, first_v[1].pd}), 32'({16'd0, 1'b1, 1'b0}));
        chk("t2_rd2", 32'({first_v[2].a, first_v[2].re, first_v[2].pd}), 32'({16'd4, 1'b1, 1'b0}));
        chk("t2_pads", pad_n, 0);

        do_run(4, 4, 3, 0, 1, 7, 3, 0);
        chk("t3_done_cycle", done_cyc, 124);
        chk("t3_kernel_clks", kclk_n, 24);
        chk("t3_writes", wen_n, 16);

        do_run(4, 4, 4, 0, 1, 0, 0, 0);
        chk("t4_even_n_done", done_cyc, 1);
        chk("t4_even_n_reads", ren_n + wen_n, 0);
        do_run(4, 4, 3, 0, 0, 0, 0, 0);
        chk("t4_zero_chans_done", done_cyc, 1);
        do_run(0, 4, 3, 0, 1, 0, 0, 0);
        chk("t4_zero_h_done", done_cyc, 1);

        do_run(3, 3, 1, 0, 2, 0, 0, 0);
        chk("t5_done_cycle", done_cyc, 55);
        chk("t5_reads", ren_n, 18);
        chk("t5_writes", wen_n, 18);
        chk("t5_newlines", nl_n, 6);

        do_run(4, 4, 3, 0, 1, 0, 0, 20);
        do_run(4, 4, 3, 0, 1, 0, 0, 0);
        chk("t6_restart_newline", 32'(first_v[0].nl), 32'd1);
        chk("t6_restart_addr", 32'(first_v[0].a), 32'd0);
        chk("t6_done_cycle", done_cyc, 121);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
